// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
// Holds the transmitter state encoding, mouse command bytes, frame
// geometry, the timer width and the odd-parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_SEND    = 3'd3,
        ST_ACK     = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    localparam int BYTE_W = 8;

    // Mouse command bytes
    localparam logic [7:0] PS2_CMD_RESET       = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE      = 8'hF4;
    localparam logic [7:0] PS2_CMD_SAMPLE_RATE = 8'hF3;

    // Device-generated falls per frame: 9 payload bits, stop, ACK
    localparam int FRAME_FALLS  = 11;
    localparam int PAYLOAD_BITS = 9;

    // Wide enough for the 15 ms timeout at 65 MHz
    localparam int CNT_W = 20;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake between the init/command logic and the PS/2
// transmitter.
//   master: drives tx_valid/tx_data, observes tx_ready/tx_done/tx_error/busy
//   slave : the transmitter side
interface ps2_host_tx_if;
    import ps2_host_tx_pkg::*;

    logic              tx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_ready;
    logic              tx_done;
    logic              tx_error;
    logic              busy;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_done, tx_error, busy
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_done, tx_error, busy
    );

endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Synchronizes the raw ps2_clk/ps2_data pin levels into the clk domain and
// flags a ps2_clk falling edge. Reusable by the device-to-host receiver.
//   clk, rst  : system clock, async active-high reset
//   clk_in    : raw ps2_clk level      data_in  : raw ps2_data level
//   clk_sync  : synchronized ps2_clk   data_sync: synchronized ps2_data
//   fall      : one-cycle flag, synchronized ps2_clk went 1 -> 0
module ps2_host_tx_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;

    // Synchronizer chains plus one extra clk flop for edge detection.
    // Reset to the idle-high line level so no false fall follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], clk_in};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], data_in};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign clk_sync  = clk_sync_r[SYNC_STAGES-1];
    assign data_sync = data_sync_r[SYNC_STAGES-1];
    assign fall      = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (mouse command direction).
// Performs request-to-send (clock inhibit, then data low), shifts out
// D0..D7 + odd parity on device clock falls, releases for the stop bit,
// samples the device ACK and waits for the bus to go idle.
//   clk, rst              : system clock, async active-high reset
//   bus (slave)           : tx_valid/tx_data request, tx_ready, tx_done,
//                           tx_error pulses, busy
//   ps2_clk_in/data_in    : raw pin levels (asynchronous)
//   ps2_clk_oe/data_oe    : 1 pulls the line low, 0 releases it
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int REQ_CYCLES     = 65,
    parameter int TIMEOUT_CYCLES = 975000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic clk_sync_s, data_sync_s, fall_s;

    ps2_host_tx_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync_s),
        .data_sync (data_sync_s),
        .fall      (fall_s)
    );

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       bit_cnt_r, bit_cnt_s;
    logic [8:0]       shreg_r, shreg_s;
    logic             ack_ok_r, ack_ok_s;
    logic             idle_seen_r, idle_seen_s;
    logic             clk_oe_r, clk_oe_s;
    logic             data_oe_r, data_oe_s;
    logic             done_r, done_s;
    logic             error_r, error_s;
    logic             tx_ready_r, busy_r;

    // Next-state, datapath and next-output logic for the transmit sequence.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shreg_s     = shreg_r;
        ack_ok_s    = ack_ok_r;
        idle_seen_s = idle_seen_r;
        clk_oe_s    = clk_oe_r;
        data_oe_s   = data_oe_r;
        done_s      = 1'b0;
        error_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                if (bus.tx_valid && tx_ready_r) begin
                    shreg_s  = {odd_parity(bus.tx_data), bus.tx_data};
                    cnt_s    = {CNT_W{1'b0}};
                    clk_oe_s = 1'b1;
                    state_s  = ST_INHIBIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (cnt_r == INH_LAST) begin
                    cnt_s     = {CNT_W{1'b0}};
                    data_oe_s = 1'b1;
                    state_s   = ST_REQ;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_REQ: begin
                if (cnt_r == REQ_LAST) begin
                    cnt_s     = {CNT_W{1'b0}};
                    bit_cnt_s = 4'd0;
                    clk_oe_s  = 1'b0;
                    state_s   = ST_SEND;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_SEND: begin
                if (fall_s) begin
                    cnt_s     = {CNT_W{1'b0}};
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    if (bit_cnt_r < 4'(PAYLOAD_BITS)) begin
                        // Open-drain: enabling the driver puts a 0 on the wire
                        data_oe_s = ~shreg_r[0];
                        shreg_s   = {1'b0, shreg_r[8:1]};
                    end else begin
                        data_oe_s = 1'b0;
                        state_s   = ST_ACK;
                    end
                end else if (cnt_r == TO_LAST) begin
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                    error_s   = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_ACK: begin
                if (fall_s) begin
                    ack_ok_s    = ~data_sync_s;
                    cnt_s       = {CNT_W{1'b0}};
                    idle_seen_s = 1'b0;
                    state_s     = ST_RECOVER;
                end else if (cnt_r == TO_LAST) begin
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                    error_s   = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_RECOVER: begin
                // Bus must read idle (clk=1, data=1) on two consecutive cycles
                if (clk_sync_s && data_sync_s && idle_seen_r) begin
                    done_s  = ack_ok_r;
                    error_s = ~ack_ok_r;
                    state_s = ST_IDLE;
                end else if (fall_s) begin
                    cnt_s       = {CNT_W{1'b0}};
                    idle_seen_s = 1'b0;
                end else if (cnt_r == TO_LAST) begin
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                    error_s   = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s       = cnt_r + 1'b1;
                    idle_seen_s = clk_sync_s & data_sync_s;
                end
            end
            default: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset releases both lines at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bit_cnt_r   <= 4'd0;
            shreg_r     <= 9'd0;
            ack_ok_r    <= 1'b0;
            idle_seen_r <= 1'b0;
            clk_oe_r    <= 1'b0;
            data_oe_r   <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            tx_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shreg_r     <= shreg_s;
            ack_ok_r    <= ack_ok_s;
            idle_seen_r <= idle_seen_s;
            clk_oe_r    <= clk_oe_s;
            data_oe_r   <= data_oe_s;
            done_r      <= done_s;
            error_r     <= error_s;
            // Ready waits one cycle after a done/error pulse
            tx_ready_r  <= (state_s == ST_IDLE) && !done_s && !error_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign bus.tx_ready = tx_ready_r;
    assign bus.tx_done  = done_r;
    assign bus.tx_error = error_r;
    assign bus.busy     = busy_r;
    assign ps2_clk_oe   = clk_oe_r;
    assign ps2_data_oe  = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx with a behavioural PS/2 device model.
// Timing parameters are shortened so the whole run stays small.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH = 40;
    localparam int REQ = 6;
    localparam int TO  = 1500;
    localparam int HP  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_line, ps2_data_line;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int inh_cnt = 0;
    int req_cnt = 0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Open-drain wired-AND of host and device drivers with pull-ups
    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Running tallies sampled mid-cycle
    always @(negedge clk) begin
        if (bus.tx_done)                  done_cnt <= done_cnt + 1;
        if (bus.tx_error)                 err_cnt  <= err_cnt + 1;
        if (ps2_clk_oe && !ps2_data_oe)   inh_cnt  <= inh_cnt + 1;
        if (ps2_clk_oe && ps2_data_oe)    req_cnt  <= req_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!bus.tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_before_send", {31'd0, bus.tx_ready}, 32'd1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Device side: waits for request-to-send, then clocks nfalls falls
    task automatic dev_frame(input int nfalls, input logic ack,
                             output logic [10:0] bits, output logic ok);
        int n;
        bits = 11'd0;
        ok   = 1'b0;
        n    = 0;
        while (!(ps2_clk_line && !ps2_data_line) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n < 600) begin
            ok = 1'b1;
            repeat (5) @(negedge clk);
            bits[0] = ps2_data_line;
            for (int i = 1; i <= nfalls; i++) begin
                if (i == FRAME_FALLS) begin
                    dev_data_low = ack;
                    repeat (4) @(negedge clk);
                end
                dev_clk_low = 1'b1;
                repeat (HP) @(negedge clk);
                dev_clk_low = 1'b0;
                if (i < FRAME_FALLS) bits[i] = ps2_data_line;
                if (i == nfalls) begin
                    dev_data_low = 1'b0;
                end else begin
                    repeat (HP) @(negedge clk);
                end
            end
        end
    endtask

    task automatic wait_pulse(output logic got_done, output logic got_err);
        int n;
        got_done = 1'b0;
        got_err  = 1'b0;
        n = 0;
        while (!(got_done || got_err) && n < 400) begin
            @(negedge clk);
            got_done = bus.tx_done;
            got_err  = bus.tx_error;
            n++;
        end
        if (n >= 400) check_eq("pulse_wait_expired", 32'd1, 32'd0);
    endtask

    // Full frame: expected parity bit is supplied from the vector table
    task automatic run_frame(input string tag, input logic [7:0] b, input logic par, input logic ack);
        logic [10:0] bits;
        logic ok, d, e;
        int d0, e0, i0, r0;
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = req_cnt;
        send_byte(b);
        check_eq({tag, "_ready_drop"}, {31'd0, bus.tx_ready}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        dev_frame(FRAME_FALLS, ack, bits, ok);
        check_eq({tag, "_rts_seen"}, {31'd0, ok}, 32'd1);
        check_eq({tag, "_frame"}, {21'd0, bits}, {21'd0, 1'b1, par, b, 1'b0});
        wait_pulse(d, e);
        check_eq({tag, "_done"}, {31'd0, d}, {31'd0, ack});
        check_eq({tag, "_error"}, {31'd0, e}, {31'd0, ~ack});
        check_eq({tag, "_ready_in_pulse"}, {31'd0, bus.tx_ready}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_ready_after"}, {31'd0, bus.tx_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check_eq({tag, "_done_count"}, done_cnt - d0, {31'd0, ack});
        check_eq({tag, "_err_count"}, err_cnt - e0, {31'd0, ~ack});
        check_eq({tag, "_inhibit_len"}, inh_cnt - i0, INH);
        check_eq({tag, "_req_len"}, req_cnt - r0, REQ);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[4] = '{
        '{8'hF4, 1'b0},
        '{8'h00, 1'b1},
        '{8'hFF, 1'b1},
        '{8'h01, 1'b0}
    };

    initial begin
        logic [10:0] bits;
        logic ok, d, e;
        int n, t0, d0;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
        check_eq("rst_done", {31'd0, bus.tx_done}, 32'd0);
        check_eq("rst_error", {31'd0, bus.tx_error}, 32'd0);
        check_eq("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check_eq("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Normal send and parity vectors
        foreach (vecs[k]) run_frame($sformatf("byte%02h", vecs[k].data), vecs[k].data, vecs[k].par, 1'b1);

        // NACK
        run_frame("nack", PS2_CMD_RESET, 1'b1, 1'b0);

        // Timeout: device never clocks after the request
        send_byte(PS2_CMD_SAMPLE_RATE);
        n = 0;
        while (ps2_clk_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_clk_release", {31'd0, ps2_clk_oe}, 32'd0);
        t0 = cyc;
        n = 0;
        while (!bus.tx_error && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_latency", cyc - t0, TO);
        check_eq("to_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check_eq("to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check_eq("to_done", {31'd0, bus.tx_done}, 32'd0);
        @(negedge clk);
        check_eq("to_ready_next", {31'd0, bus.tx_ready}, 32'd1);

        // Reset during inhibit releases the clock line immediately
        send_byte(PS2_CMD_ENABLE);
        repeat (10) @(negedge clk);
        check_eq("rinh_clk_held", {31'd0, ps2_clk_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rinh_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset after fall 5 of a 0x00 frame (data driven low at that point)
        send_byte(8'h00);
        dev_frame(5, 1'b0, bits, ok);
        check_eq("rmid_rts_seen", {31'd0, ok}, 32'd1);
        check_eq("rmid_data_held", {31'd0, ps2_data_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rmid_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check_eq("rmid_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check_eq("rmid_ready", {31'd0, bus.tx_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_frame("after_rst", PS2_CMD_RESET, 1'b1, 1'b1);

        // Back-to-back with tx_valid held high
        d0 = done_cnt;
        bus.tx_valid = 1'b1;
        bus.tx_data  = PS2_CMD_SAMPLE_RATE;
        @(negedge clk);
        bus.tx_data  = 8'h64;
        check_eq("b2b_busy1", {31'd0, bus.busy}, 32'd1);
        dev_frame(FRAME_FALLS, 1'b1, bits, ok);
        check_eq("b2b_frame1", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'hF3, 1'b0});
        wait_pulse(d, e);
        check_eq("b2b_done1", {31'd0, d}, 32'd1);
        check_eq("b2b_ready_in_pulse", {31'd0, bus.tx_ready}, 32'd0);
        @(negedge clk);
        check_eq("b2b_ready_gap", {31'd0, bus.tx_ready}, 32'd1);
        @(negedge clk);
        check_eq("b2b_accept2", {31'd0, bus.busy}, 32'd1);
        dev_frame(FRAME_FALLS, 1'b1, bits, ok);
        check_eq("b2b_frame2", {21'd0, bits}, {21'd0, 1'b1, 1'b0, 8'h64, 1'b0});
        wait_pulse(d, e);
        bus.tx_valid = 1'b0;
        check_eq("b2b_done2", {31'd0, d}, 32'd1);
        repeat (5) @(negedge clk);
        check_eq("b2b_done_count", done_cnt - d0, 32'd2);
        check_eq("b2b_idle", {31'd0, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
